// File: rtl/calendar_counter.sv
// calendar_counter
//   BCD month/day/year calendar stage driven by the hours-wrap carry.
//   Knows month lengths, handles February in leap years, and accepts a
//   validated parallel date load.
//
// Optional feature macro: LEAP_YEAR_EN
//   defined   : Gregorian leap rule, February has 29 days in leap years,
//               leap output is live.
//   undefined : February is always 28 days, leap is tied low, and a load
//               of 02/29 is rejected.
//
// Parameters
//   YEAR_MIN  lowest year (BCD); reset year and wrap target
//   YEAR_MAX  highest year (BCD); stepping past Dec 31 of it wraps to YEAR_MIN
//
// Ports
//   clk                 system clock
//   rst_n               asynchronous active-low reset
//   en                  day-advance strobe, one day per cycle while high
//   load                parallel date load strobe (wins over en)
//   ld_month/ld_day     BCD load month / day {tens,ones}
//   ld_year             BCD load year {thousands..ones}
//   month1..yr0         registered BCD date digits
//   leap                current year is a leap year (combinational)
//   wrap                one-cycle pulse: year wrapped YEAR_MAX -> YEAR_MIN
//   ld_err              one-cycle pulse: load rejected
module calendar_counter #(
  parameter logic [15:0] YEAR_MIN = 16'h2000,
  parameter logic [15:0] YEAR_MAX = 16'h9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [7:0]  ld_month,
  input  logic [7:0]  ld_day,
  input  logic [15:0] ld_year,
  output logic [3:0]  month1,
  output logic [3:0]  month0,
  output logic [3:0]  day1,
  output logic [3:0]  day0,
  output logic [3:0]  yr3,
  output logic [3:0]  yr2,
  output logic [3:0]  yr1,
  output logic [3:0]  yr0,
  output logic        leap,
  output logic        wrap,
  output logic        ld_err
);

  logic [7:0]  month_reg, month_next;
  logic [7:0]  day_reg, day_next;
  logic [15:0] year_reg, year_next;
  logic        wrap_reg, wrap_next;
  logic        ld_err_reg, ld_err_next;

  logic        leap_cur;   // leap status of the current year
  logic        leap_ld;    // leap status of the year being loaded

`ifdef LEAP_YEAR_EN
  // Divisibility by 4 of a two-digit BCD number: an even tens digit needs
  // ones in {0,4,8}; an odd tens digit contributes 10 mod 4 = 2, so ones
  // must be in {2,6}.
  function automatic logic div4(input logic [3:0] t, input logic [3:0] o);
    if (t[0]) return (o == 4'd2) || (o == 4'd6);
    else      return (o == 4'd0) || (o == 4'd4) || (o == 4'd8);
  endfunction

  // Century years are leap only when divisible by 400, i.e. when the
  // upper two digits are divisible by 4.
  function automatic logic is_leap(input logic [15:0] y);
    if (y[7:0] == 8'h00) return div4(y[15:12], y[11:8]);
    else                 return div4(y[7:4], y[3:0]);
  endfunction

  assign leap_cur = is_leap(year_reg);
  assign leap_ld  = is_leap(ld_year);
`else
  assign leap_cur = 1'b0;
  assign leap_ld  = 1'b0;
`endif

  // Month length as a BCD day number.
  function automatic logic [7:0] month_len(input logic [7:0] m, input logic lp);
    case (m)
      8'h02:                      return lp ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

  // Two-digit BCD increment (09 -> 10, 19 -> 20, ...).
  function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Four-digit BCD year increment as a digit ripple.
  logic [3:0]  yr_carry;
  logic [15:0] year_inc;
  assign yr_carry[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_year_inc
      assign year_inc[gi*4 +: 4] = !yr_carry[gi] ? year_reg[gi*4 +: 4] :
                                   (year_reg[gi*4 +: 4] == 4'd9) ? 4'd0 :
                                   year_reg[gi*4 +: 4] + 4'd1;
      if (gi < 3) begin : g_carry
        assign yr_carry[gi+1] = yr_carry[gi] & (year_reg[gi*4 +: 4] == 4'd9);
      end
    end
  endgenerate

  // Load validation: every nibble must be a decimal digit before the
  // range compares below mean anything (valid BCD orders like binary).
  logic [31:0] ld_all;
  logic [7:0]  nib_ok;
  assign ld_all = {ld_month, ld_day, ld_year};

  generate
    for (gi = 0; gi < 8; gi++) begin : g_nib_ok
      assign nib_ok[gi] = (ld_all[gi*4 +: 4] <= 4'd9);
    end
  endgenerate

  logic ld_ok;
  assign ld_ok = (&nib_ok) &&
                 (ld_month >= 8'h01) && (ld_month <= 8'h12) &&
                 (ld_day >= 8'h01) && (ld_day <= month_len(ld_month, leap_ld)) &&
                 (ld_year >= YEAR_MIN) && (ld_year <= YEAR_MAX);

  always_comb begin
    month_next  = month_reg;
    day_next    = day_reg;
    year_next   = year_reg;
    wrap_next   = 1'b0;
    ld_err_next = 1'b0;
    if (load) begin
      if (ld_ok) begin
        month_next = ld_month;
        day_next   = ld_day;
        year_next  = ld_year;
      end else begin
        ld_err_next = 1'b1;
      end
    end else if (en) begin
      // ">=" keeps the counter self-correcting should a day ever exceed
      // its month length.
      if (day_reg < month_len(month_reg, leap_cur)) begin
        day_next = bcd2_inc(day_reg);
      end else begin
        day_next = 8'h01;
        if (month_reg < 8'h12) begin
          month_next = bcd2_inc(month_reg);
        end else begin
          month_next = 8'h01;
          if (year_reg == YEAR_MAX) begin
            year_next = YEAR_MIN;
            wrap_next = 1'b1;
          end else begin
            year_next = year_inc;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      month_reg  <= 8'h01;
      day_reg    <= 8'h01;
      year_reg   <= YEAR_MIN;
      wrap_reg   <= 1'b0;
      ld_err_reg <= 1'b0;
    end else begin
      month_reg  <= month_next;
      day_reg    <= day_next;
      year_reg   <= year_next;
      wrap_reg   <= wrap_next;
      ld_err_reg <= ld_err_next;
    end
  end

  assign {month1, month0}      = month_reg;
  assign {day1, day0}          = day_reg;
  assign {yr3, yr2, yr1, yr0}  = year_reg;
  assign leap                  = leap_cur;
  assign wrap                  = wrap_reg;
  assign ld_err                = ld_err_reg;

endmodule

// File: tb/tb_calendar_counter.sv
// Directed, table-driven bench for calendar_counter. Expectations that depend
// on the LEAP_YEAR_EN build option are selected with LEAP_ON.
module tb_calendar_counter;

`ifdef LEAP_YEAR_EN
  localparam bit LEAP_ON = 1'b1;
`else
  localparam bit LEAP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [7:0]  ld_month;
  logic [7:0]  ld_day;
  logic [15:0] ld_year;
  logic [3:0]  month1, month0, day1, day0, yr3, yr2, yr1, yr0;
  logic        leap, wrap, ld_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  calendar_counter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .load     (load),
    .ld_month (ld_month),
    .ld_day   (ld_day),
    .ld_year  (ld_year),
    .month1   (month1),
    .month0   (month0),
    .day1     (day1),
    .day0     (day0),
    .yr3      (yr3),
    .yr2      (yr2),
    .yr1      (yr1),
    .yr0      (yr0),
    .leap     (leap),
    .wrap     (wrap),
    .ld_err   (ld_err)
  );

  typedef struct {
    string       name;
    logic        ld;
    logic        en;
    logic [7:0]  lm;
    logic [7:0]  ldd;
    logic [15:0] ly;
    int          reps;
    logic [7:0]  em;
    logic [7:0]  ed;
    logic [15:0] ey;
    logic        el;
    logic        ew;
    logic        ee;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic l, input logic e,
                              input logic [7:0] lm, input logic [7:0] ldd,
                              input logic [15:0] ly, input int reps,
                              input logic [7:0] em, input logic [7:0] ed,
                              input logic [15:0] ey, input logic el,
                              input logic ew, input logic ee);
    vec_t v;
    v.name = name; v.ld = l; v.en = e; v.lm = lm; v.ldd = ldd; v.ly = ly;
    v.reps = reps; v.em = em; v.ed = ed; v.ey = ey; v.el = el; v.ew = ew;
    v.ee = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_state(input string nm, input logic [7:0] em, input logic [7:0] ed,
                           input logic [15:0] ey, input logic el, input logic ew,
                           input logic ee);
    chk({nm, " month"},  {8'h00, month1, month0}, {8'h00, em});
    chk({nm, " day"},    {8'h00, day1, day0},     {8'h00, ed});
    chk({nm, " year"},   {yr3, yr2, yr1, yr0},    ey);
    chk({nm, " leap"},   {15'h0, leap},           {15'h0, el});
    chk({nm, " wrap"},   {15'h0, wrap},           {15'h0, ew});
    chk({nm, " ld_err"}, {15'h0, ld_err},         {15'h0, ee});
    $display("%-22s -> %h%h/%h%h/%h%h%h%h leap=%b wrap=%b ld_err=%b", nm,
             month1, month0, day1, day0, yr3, yr2, yr1, yr0, leap, wrap, ld_err);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0;
    ld_month = 8'h00; ld_day = 8'h00; ld_year = 16'h0000;

    // Stimulus table: each row is applied 'reps' cycles, then checked.
    vecs.push_back(mk("load 01/31/2001",  1,0, 8'h01,8'h31,16'h2001, 1, 8'h01,8'h31,16'h2001, 0,0,0));
    vecs.push_back(mk("en Jan->Feb",      0,1, 8'h00,8'h00,16'h0000, 1, 8'h02,8'h01,16'h2001, 0,0,0));
    vecs.push_back(mk("en x27",           0,1, 8'h00,8'h00,16'h0000,27, 8'h02,8'h28,16'h2001, 0,0,0));
    vecs.push_back(mk("en Feb28 2001",    0,1, 8'h00,8'h00,16'h0000, 1, 8'h03,8'h01,16'h2001, 0,0,0));
    vecs.push_back(mk("load 02/28/2000",  1,0, 8'h02,8'h28,16'h2000, 1, 8'h02,8'h28,16'h2000, LEAP_ON,0,0));
    vecs.push_back(mk("en Feb28 2000",    0,1, 8'h00,8'h00,16'h0000, 1,
                      LEAP_ON ? 8'h02 : 8'h03, LEAP_ON ? 8'h29 : 8'h01, 16'h2000, LEAP_ON,0,0));
    vecs.push_back(mk("en again 2000",    0,1, 8'h00,8'h00,16'h0000, 1,
                      8'h03, LEAP_ON ? 8'h01 : 8'h02, 16'h2000, LEAP_ON,0,0));
    vecs.push_back(mk("load 02/28/2100",  1,0, 8'h02,8'h28,16'h2100, 1, 8'h02,8'h28,16'h2100, 0,0,0));
    vecs.push_back(mk("en Feb28 2100",    0,1, 8'h00,8'h00,16'h0000, 1, 8'h03,8'h01,16'h2100, 0,0,0));
    vecs.push_back(mk("load 12/31/9999",  1,0, 8'h12,8'h31,16'h9999, 1, 8'h12,8'h31,16'h9999, 0,0,0));
    vecs.push_back(mk("en year wrap",     0,1, 8'h00,8'h00,16'h0000, 1, 8'h01,8'h01,16'h2000, LEAP_ON,1,0));
    vecs.push_back(mk("idle after wrap",  0,0, 8'h00,8'h00,16'h0000, 1, 8'h01,8'h01,16'h2000, LEAP_ON,0,0));
    vecs.push_back(mk("load 02/29/2001",  1,0, 8'h02,8'h29,16'h2001, 1, 8'h01,8'h01,16'h2000, LEAP_ON,0,1));
    vecs.push_back(mk("idle after reject",0,0, 8'h00,8'h00,16'h0000, 1, 8'h01,8'h01,16'h2000, LEAP_ON,0,0));
    vecs.push_back(mk("load 13/01/2005",  1,0, 8'h13,8'h01,16'h2005, 1, 8'h01,8'h01,16'h2000, LEAP_ON,0,1));
    vecs.push_back(mk("load 1A/01/2005",  1,0, 8'h1A,8'h01,16'h2005, 1, 8'h01,8'h01,16'h2000, LEAP_ON,0,1));
    vecs.push_back(mk("load 04/31/2023",  1,0, 8'h04,8'h31,16'h2023, 1, 8'h01,8'h01,16'h2000, LEAP_ON,0,1));
    vecs.push_back(mk("load 01/01/1999",  1,0, 8'h01,8'h01,16'h1999, 1, 8'h01,8'h01,16'h2000, LEAP_ON,0,1));
    vecs.push_back(mk("load 05/00/2005",  1,0, 8'h05,8'h00,16'h2005, 1, 8'h01,8'h01,16'h2000, LEAP_ON,0,1));
    vecs.push_back(mk("load+en 06/15/2024",1,1,8'h06,8'h15,16'h2024, 1, 8'h06,8'h15,16'h2024, LEAP_ON,0,0));
    vecs.push_back(mk("en 06/15/2024",    0,1, 8'h00,8'h00,16'h0000, 1, 8'h06,8'h16,16'h2024, LEAP_ON,0,0));
    vecs.push_back(mk("load 02/29/2024",  1,0, 8'h02,8'h29,16'h2024, 1,
                      LEAP_ON ? 8'h02 : 8'h06, LEAP_ON ? 8'h29 : 8'h16, 16'h2024, LEAP_ON,0,!LEAP_ON));
    vecs.push_back(mk("en after 02/29",   0,1, 8'h00,8'h00,16'h0000, 1,
                      LEAP_ON ? 8'h03 : 8'h06, LEAP_ON ? 8'h01 : 8'h17, 16'h2024, LEAP_ON,0,0));
    vecs.push_back(mk("load 09/30/2023",  1,0, 8'h09,8'h30,16'h2023, 1, 8'h09,8'h30,16'h2023, 0,0,0));
    vecs.push_back(mk("en Sep->Oct",      0,1, 8'h00,8'h00,16'h0000, 1, 8'h10,8'h01,16'h2023, 0,0,0));
    vecs.push_back(mk("load 01/19/2000",  1,0, 8'h01,8'h19,16'h2000, 1, 8'h01,8'h19,16'h2000, LEAP_ON,0,0));
    vecs.push_back(mk("en 19->20",        0,1, 8'h00,8'h00,16'h0000, 1, 8'h01,8'h20,16'h2000, LEAP_ON,0,0));
    vecs.push_back(mk("en x12",           0,1, 8'h00,8'h00,16'h0000,12, 8'h02,8'h01,16'h2000, LEAP_ON,0,0));
    vecs.push_back(mk("load 12/31/2099",  1,0, 8'h12,8'h31,16'h2099, 1, 8'h12,8'h31,16'h2099, 0,0,0));
    vecs.push_back(mk("en year ripple",   0,1, 8'h00,8'h00,16'h0000, 1, 8'h01,8'h01,16'h2100, 0,0,0));
    vecs.push_back(mk("load 00/05/2005",  1,0, 8'h00,8'h05,16'h2005, 1, 8'h01,8'h01,16'h2100, 0,0,1));

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 8'h01, 8'h01, 16'h2000, LEAP_ON, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        @(negedge clk);
        load = vecs[i].ld; en = vecs[i].en;
        ld_month = vecs[i].lm; ld_day = vecs[i].ldd; ld_year = vecs[i].ly;
        @(posedge clk);
        #1;
      end
      chk_state(vecs[i].name, vecs[i].em, vecs[i].ed, vecs[i].ey,
                vecs[i].el, vecs[i].ew, vecs[i].ee);
      load = 1'b0; en = 1'b0;
    end

    // Asynchronous reset mid-count while ld_err is high and en is active.
    @(negedge clk);
    load = 1'b1; ld_month = 8'h13; ld_day = 8'h01; ld_year = 16'h2005;
    @(posedge clk);
    #1;
    chk_state("reject before reset", 8'h01, 8'h01, 16'h2100, 1'b0, 1'b0, 1'b1);
    load = 1'b0; en = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk_state("async reset", 8'h01, 8'h01, 16'h2000, LEAP_ON, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0;
    @(posedge clk);
    #1;
    chk_state("after reset release", 8'h01, 8'h01, 16'h2000, LEAP_ON, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
